// File: rtl/mcp3008_pkg.sv
// Shared definitions for the MCP3008 pin-level SPI responder.
// State encoding and protocol field widths.
package mcp3008_pkg;

  localparam int CMD_BITS  = 4;
  localparam int DATA_BITS = 10;

  localparam logic [3:0] CMD_CNT   = 4'(CMD_BITS);
  localparam logic [3:0] CMD_LAST  = 4'(CMD_BITS - 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_START = 3'd1,
    ST_CMD        = 3'd2,
    ST_SAMPLE     = 3'd3,
    ST_NULL       = 3'd4,
    ST_DATA       = 3'd5,
    ST_DONE       = 3'd6
  } state_t;

  // A chip-select release in these states cuts a transfer short.
  function automatic logic is_abortable(input state_t s);
    return (s == ST_CMD) || (s == ST_SAMPLE) || (s == ST_NULL) || (s == ST_DATA);
  endfunction

endpackage

// File: rtl/mcp3008_spi_responder_spi_pin_sync.sv
// Multi-stage synchronizer with registered rise/fall detection for one SPI pin.
// level is delayed to line up with the rise/fall pulses so data pins stay aligned with the clock pin.
module spi_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], pin};
      prev_q <= sync_q[STAGES-1];
      rise   <= sync_q[STAGES-1] & ~prev_q;
      fall   <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign level = prev_q;

endmodule

// File: rtl/mcp3008_spi_responder.sv
// Pin-level MCP3008 emulation: decodes the start/SGL/channel command, reports it,
// then shifts a null bit and the supplied 10-bit sample back MSB-first.
module mcp3008_spi_responder
  import mcp3008_pkg::*;
#(
  parameter int   SYNC_STAGES = 2,
  parameter logic IDLE_MISO   = 1'b0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        adc_cs,
  input  logic        adc_clk,
  input  logic        adc_mosi,
  output logic        adc_miso,
  output logic        adc_miso_oe,
  input  logic [9:0]  sample_value,
  output logic        req_strobe,
  output logic [2:0]  req_channel,
  output logic        req_diffn,
  output logic        xfer_done,
  output logic        aborted,
  output state_t      dbg_state
);

  logic cs_level, cs_rise, cs_fall;
  logic clk_level, clk_rise, clk_fall;
  logic mosi_level, mosi_rise, mosi_fall;
  logic unused_pins;

  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_cs_sync (
    .clock(clock), .reset(reset), .pin(adc_cs),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_clk_sync (
    .clock(clock), .reset(reset), .pin(adc_clk),
    .level(clk_level), .rise(clk_rise), .fall(clk_fall)
  );
  spi_pin_sync #(.STAGES(SYNC_STAGES)) u_mosi_sync (
    .clock(clock), .reset(reset), .pin(adc_mosi),
    .level(mosi_level), .rise(mosi_rise), .fall(mosi_fall)
  );

  assign unused_pins = ^{cs_level, clk_level, mosi_rise, mosi_fall};

  state_t      state_q, state_d;
  logic [3:0]  bitcnt_q, bitcnt_d;
  logic [2:0]  shadow_q, shadow_d;
  logic [9:0]  shift_q, shift_d;
  logic        miso_q, miso_d;
  logic        oe_q, oe_d;
  logic        strobe_q, strobe_d;
  logic [2:0]  chan_q, chan_d;
  logic        diffn_q, diffn_d;
  logic        done_q, done_d;
  logic        abort_q, abort_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      bitcnt_q <= '0;
      shadow_q <= '0;
      shift_q  <= '0;
      miso_q   <= IDLE_MISO;
      oe_q     <= 1'b0;
      strobe_q <= 1'b0;
      chan_q   <= '0;
      diffn_q  <= 1'b0;
      done_q   <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      shadow_q <= shadow_d;
      shift_q  <= shift_d;
      miso_q   <= miso_d;
      oe_q     <= oe_d;
      strobe_q <= strobe_d;
      chan_q   <= chan_d;
      diffn_q  <= diffn_d;
      done_q   <= done_d;
      abort_q  <= abort_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    shadow_d = shadow_q;
    shift_d  = shift_q;
    miso_d   = miso_q;
    oe_d     = oe_q;
    strobe_d = 1'b0;
    chan_d   = chan_q;
    diffn_d  = diffn_q;
    done_d   = 1'b0;
    abort_d  = 1'b0;

    // Chip-select release outranks any simultaneous SCLK edge.
    if (cs_rise) begin
      state_d = ST_IDLE;
      oe_d    = 1'b0;
      miso_d  = IDLE_MISO;
      abort_d = is_abortable(state_q);
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (cs_fall) state_d = ST_WAIT_START;
        end
        ST_WAIT_START: begin
          if (clk_rise && mosi_level) begin
            state_d  = ST_CMD;
            bitcnt_d = '0;
          end
        end
        ST_CMD: begin
          // bitcnt == CMD_BITS is the one-cycle slot that issues the strobe.
          if (bitcnt_q == CMD_CNT) begin
            strobe_d = 1'b1;
            state_d  = ST_SAMPLE;
          end else if (clk_rise) begin
            shadow_d = {shadow_q[1:0], mosi_level};
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == CMD_LAST) begin
              diffn_d = shadow_q[2];
              chan_d  = {shadow_q[1:0], mosi_level};
            end
          end
        end
        ST_SAMPLE: begin
          if (clk_fall) state_d = ST_NULL;
        end
        ST_NULL: begin
          if (clk_fall) begin
            shift_d  = sample_value;
            miso_d   = 1'b0;
            oe_d     = 1'b1;
            bitcnt_d = DATA_LAST;
            state_d  = ST_DATA;
          end
        end
        ST_DATA: begin
          if (clk_fall) begin
            miso_d = shift_q[bitcnt_q];
            if (bitcnt_q == 4'd0) begin
              done_d  = 1'b1;
              state_d = ST_DONE;
            end else begin
              bitcnt_d = bitcnt_q - 4'd1;
            end
          end
        end
        ST_DONE: begin
          if (clk_fall) miso_d = 1'b0;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  assign adc_miso    = miso_q;
  assign adc_miso_oe = oe_q;
  assign req_strobe  = strobe_q;
  assign req_channel = chan_q;
  assign req_diffn   = diffn_q;
  assign xfer_done   = done_q;
  assign aborted     = abort_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mcp3008_spi_responder.sv
// Directed bench for the MCP3008 responder: SPI controller driver tasks, pulse monitor,
// hand-computed expected values and a single summary line.
module tb_mcp3008_spi_responder;
  import mcp3008_pkg::*;

  localparam int SYNC      = 2;
  localparam int HALF_FAST = 5;
  localparam int HALF_SLOW = 25;
  localparam int FULL_RISES = 17;

  // Clock / reset
  logic       clock = 1'b0;
  logic       reset;
  logic       adc_cs, adc_clk, adc_mosi;
  logic       adc_miso, adc_miso_oe;
  logic [9:0] sample_value;
  logic       req_strobe, req_diffn, xfer_done, aborted;
  logic [2:0] req_channel;
  state_t     dbg_state;

  always #10 clock = ~clock;

  mcp3008_spi_responder #(.SYNC_STAGES(SYNC), .IDLE_MISO(1'b0)) dut (
    .clock(clock), .reset(reset),
    .adc_cs(adc_cs), .adc_clk(adc_clk), .adc_mosi(adc_mosi),
    .adc_miso(adc_miso), .adc_miso_oe(adc_miso_oe),
    .sample_value(sample_value),
    .req_strobe(req_strobe), .req_channel(req_channel), .req_diffn(req_diffn),
    .xfer_done(xfer_done), .aborted(aborted), .dbg_state(dbg_state)
  );

  // Scoreboard counters and check task
  int err_cnt = 0;
  int chk_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Pulse monitor
  int n_strobe = 0, n_done = 0, n_abort = 0, n_overlap = 0, n_unstable = 0;

  always @(negedge clock) begin
    if (req_strobe === 1'b1) n_strobe++;
    if (xfer_done === 1'b1) n_done++;
    if (aborted === 1'b1) n_abort++;
    if ((int'(req_strobe) + int'(xfer_done) + int'(aborted)) > 1) n_overlap++;
  end

  // Driver: one SPI transfer of n_rises SCLK periods, mode 0, reading miso on each rising edge.
  // sample_value holds a decoy until the fall after D0, so an early latch shows up as wrong data.
  task automatic spi_xfer(input int lead, input logic sgl, input logic [2:0] ch,
                          input logic [9:0] val, input int half, input int n_rises,
                          output logic null_bit, output logic [9:0] data);
    logic m_early;
    null_bit = 1'b1;
    data = '0;
    sample_value = ~val;
    @(negedge clock);
    adc_clk = 1'b0;
    adc_mosi = 1'b0;
    adc_cs = 1'b0;
    for (int r = 1; r <= n_rises; r++) begin
      if (r <= lead) adc_mosi = 1'b0;
      else if (r == lead + 1) adc_mosi = 1'b1;
      else if (r == lead + 2) adc_mosi = sgl;
      else if (r >= lead + 3 && r <= lead + 5) adc_mosi = ch[lead + 5 - r];
      else adc_mosi = 1'b0;
      repeat (half - 1) @(negedge clock);
      m_early = adc_miso;
      @(negedge clock);
      if (adc_miso !== m_early) n_unstable++;
      if (r == lead + 7) null_bit = adc_miso;
      if (r >= lead + 8 && r <= lead + 17) data[lead + 17 - r] = adc_miso;
      adc_clk = 1'b1;
      repeat (half) @(negedge clock);
      adc_clk = 1'b0;
      if (r == lead + 5) sample_value = val;
    end
    repeat (half) @(negedge clock);
  endtask

  task automatic cs_release();
    adc_cs = 1'b1;
    repeat (SYNC + 2) @(negedge clock);
    chk("release_oe", 32'(adc_miso_oe), 32'd0);
    chk("release_miso", 32'(adc_miso), 32'd0);
    repeat (6) @(negedge clock);
  endtask

  // Full read plus pulse-count checks
  task automatic full_read(input string tag, input int lead, input logic sgl,
                           input logic [2:0] ch, input logic [9:0] val, input int half,
                           output logic [9:0] data);
    int s0, d0, a0;
    logic nb;
    s0 = n_strobe; d0 = n_done; a0 = n_abort;
    spi_xfer(lead, sgl, ch, val, half, lead + FULL_RISES, nb, data);
    chk({tag, "_null"}, 32'(nb), 32'd0);
    chk({tag, "_data"}, 32'(data), 32'(val));
    chk({tag, "_chan"}, 32'(req_channel), 32'(ch));
    chk({tag, "_diffn"}, 32'(req_diffn), 32'(sgl));
    chk({tag, "_oe_done"}, 32'(adc_miso_oe), 32'd1);
    chk({tag, "_state"}, 32'(dbg_state), 32'(ST_DONE));
    cs_release();
    chk({tag, "_strobes"}, 32'(n_strobe - s0), 32'd1);
    chk({tag, "_dones"}, 32'(n_done - d0), 32'd1);
    chk({tag, "_aborts"}, 32'(n_abort - a0), 32'd0);
  endtask

  logic [9:0] d_fast, d_slow, d_tmp;
  logic       nb_tmp;
  int         a_base, d_base;

  initial begin
    reset = 1'b1;
    adc_cs = 1'b1;
    adc_clk = 1'b0;
    adc_mosi = 1'b0;
    sample_value = '0;
    repeat (3) @(negedge clock);
    chk("rst_miso", 32'(adc_miso), 32'd0);
    chk("rst_oe", 32'(adc_miso_oe), 32'd0);
    chk("rst_pulses", 32'({req_strobe, xfer_done, aborted}), 32'd0);
    chk("rst_req", 32'({req_channel, req_diffn}), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    reset = 1'b0;
    repeat (8) @(negedge clock);

    // Single-ended ch 5
    full_read("se_ch5", 0, 1'b1, 3'd5, 10'h2A5, HALF_FAST, d_tmp);

    // Leading zeros, differential ch 2
    full_read("diff_ch2", 3, 1'b0, 3'd2, 10'h3FF, HALF_FAST, d_tmp);

    // Back-to-back, value changes between strobes
    full_read("b2b_512", 0, 1'b1, 3'd1, 10'd512, HALF_FAST, d_tmp);
    full_read("b2b_513", 0, 1'b1, 3'd1, 10'd513, HALF_FAST, d_tmp);

    // Abort after the 6th data falling edge
    a_base = n_abort; d_base = n_done;
    spi_xfer(0, 1'b1, 3'd3, 10'h155, HALF_FAST, 12, nb_tmp, d_tmp);
    chk("abort_state", 32'(dbg_state), 32'(ST_DATA));
    cs_release();
    chk("abort_pulse", 32'(n_abort - a_base), 32'd1);
    chk("abort_no_done", 32'(n_done - d_base), 32'd0);
    chk("abort_state_idle", 32'(dbg_state), 32'(ST_IDLE));
    full_read("post_abort", 0, 1'b1, 3'd3, 10'h0C3, HALF_FAST, d_tmp);

    // Reset during DATA
    spi_xfer(0, 1'b1, 3'd6, 10'h2AA, HALF_FAST, 10, nb_tmp, d_tmp);
    chk("pre_rst_state", 32'(dbg_state), 32'(ST_DATA));
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_oe", 32'(adc_miso_oe), 32'd0);
    chk("midrst_miso", 32'(adc_miso), 32'd0);
    chk("midrst_req", 32'({req_strobe, req_channel, req_diffn, xfer_done, aborted}), 32'd0);
    chk("midrst_state", 32'(dbg_state), 32'(ST_IDLE));
    repeat (2) @(negedge clock);
    reset = 1'b0;
    repeat (4) @(negedge clock);
    chk("postrst_idle", 32'(dbg_state), 32'(ST_IDLE));
    adc_cs = 1'b1;
    repeat (8) @(negedge clock);
    full_read("post_rst_ch7", 0, 1'b1, 3'd7, 10'h001, HALF_FAST, d_tmp);

    // 5 MHz against 1 MHz
    full_read("fast", 1, 1'b1, 3'd4, 10'h1C6, HALF_FAST, d_fast);
    full_read("slow", 1, 1'b1, 3'd4, 10'h1C6, HALF_SLOW, d_slow);
    chk("fast_vs_slow", 32'(d_fast ^ d_slow), 32'd0);

    chk("miso_stable", 32'(n_unstable), 32'd0);
    chk("pulse_exclusive", 32'(n_overlap), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
